// File: rtl/key_encoder10to4_if.sv
// key_encoder10to4_if
//   Groups the key encoder's data-side signals so the encoder and whatever
//   drives/consumes it share one bundle. Clock and reset stay outside.
//
//   i_key       10  raw buttons, active-low, asynchronous; i_key[n] is key n+1
//   o_data       4  code of the last accepted key (1..10), 0 after reset
//   o_valid      1  one-cycle strobe when o_data loads a newly accepted key
//   o_key_down   1  high from acceptance until every debounced key is released
//
//   master: the side that owns the buttons and consumes the code
//   slave : the encoder itself
interface key_encoder10to4_if;
  logic [9:0] i_key;
  logic [3:0] o_data;
  logic       o_valid;
  logic       o_key_down;

  modport master (
    output i_key,
    input  o_data,
    input  o_valid,
    input  o_key_down
  );

  modport slave (
    input  i_key,
    output o_data,
    output o_valid,
    output o_key_down
  );
endinterface

// File: rtl/key_encoder10to4.sv
// key_encoder10to4
//   Synchronises ten bouncing active-low push-buttons, debounces each one on
//   a slow sample tick, and encodes the lowest-index newly pressed key into a
//   4-bit code 1..10 with a single-cycle valid strobe. One press gives exactly
//   one strobe; other keys pressed while one is held are ignored until every
//   key has been released.
//
//   Parameters
//     P_CLK_DIV  sample tick period in i_clk cycles (>= 2)
//     P_DEB_CNT  consecutive differing samples needed to flip a key (>= 2)
//
//   Ports
//     i_clk  system clock, rising edge
//     i_rst  synchronous active-high reset
//     bus    key_encoder10to4_if.slave: i_key in; o_data, o_valid, o_key_down out
module key_encoder10to4 #(
  parameter int P_CLK_DIV = 50000,
  parameter int P_DEB_CNT = 20
) (
  input logic               i_clk,
  input logic               i_rst,
  key_encoder10to4_if.slave bus
);

  localparam int TICK_W = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
  localparam int DEB_W  = (P_DEB_CNT > 1) ? $clog2(P_DEB_CNT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(P_CLK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(P_DEB_CNT - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; resets to all released (active-low high level)
  // ---------------------------------------------------------------------------
  logic [9:0] key_meta;
  logic [9:0] key_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= bus.i_key;
      key_sync <= key_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running sample tick counter
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce. pressed[i] is the debounced state in active-high form.
  // A key's counter tracks consecutive ticks where the synced sample disagrees
  // with the debounced state; reaching P_DEB_CNT flips the state, and a single
  // agreeing tick discards the run.
  // ---------------------------------------------------------------------------
  logic [9:0]       pressed;
  logic [9:0]       sample_pressed;
  logic [DEB_W-1:0] deb_cnt [10];

  assign sample_pressed = ~key_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pressed <= '0;
      for (int unsigned i = 0; i < 10; i++) begin
        deb_cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int unsigned i = 0; i < 10; i++) begin
        if (sample_pressed[i] != pressed[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            pressed[i] <= sample_pressed[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lowest-index pressed key, encoded as index+1. Scanning downward lets the
  // last hit (the lowest index) win.
  // ---------------------------------------------------------------------------
  logic [3:0] low_code;

  always_comb begin
    low_code = '0;
    for (int unsigned i = 10; i > 0; i--) begin
      if (pressed[i-1]) begin
        low_code = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Encoder FSM: IDLE accepts one key, HOLD waits for a full release.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       down_q, down_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = 1'b0;
    down_d  = down_q;
    unique case (state_q)
      IDLE: begin
        if (|pressed) begin
          data_d  = low_code;
          valid_d = 1'b1;
          down_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!(|pressed)) begin
          down_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_key_down = down_q;

endmodule

// File: tb/tb_key_encoder10to4.sv
// tb_key_encoder10to4
//   Directed bench for key_encoder10to4 with P_CLK_DIV=4, P_DEB_CNT=3.
//   With those values a key held stable from before edge k produces o_valid
//   at edge k+11..k+14, so pulse/fall indices counted from that edge must lie
//   in 11..15.
module tb_key_encoder10to4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  key_encoder10to4_if bus ();

  key_encoder10to4 #(
    .P_CLK_DIV(4),
    .P_DEB_CNT(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    tests++;
    assert (got >= lo && got <= hi) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  // Steps n clock edges (index 0 is the first edge), sampling 1 time unit
  // after each. Reports valid pulses, index of first pulse and first cycle
  // with o_key_down low (-1 if none), and protocol violations: o_data moving
  // without o_valid, or o_valid high on two consecutive cycles.
  task automatic run_cycles(input int n, output int pulses, output int first_pulse,
                            output int first_low, output int bad);
    logic [3:0] prev_data;
    logic       prev_valid;
    prev_data   = bus.o_data;
    prev_valid  = bus.o_valid;
    pulses      = 0;
    first_pulse = -1;
    first_low   = -1;
    bad         = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        if (prev_valid === 1'b1) bad++;
      end else if (bus.o_data !== prev_data) begin
        bad++;
      end
      if (bus.o_key_down === 1'b0 && first_low < 0) first_low = i;
      prev_data  = bus.o_data;
      prev_valid = bus.o_valid;
    end
  endtask

  int pulses, first_pulse, first_low, bad, sum;

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    bus.i_key = 10'h3FF;

    // ---------------- Reset with key 3 held ----------------
    @(negedge clk);
    bus.i_key = 10'h3FB;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_data", int'(bus.o_data), 0);
      check("rst_valid", int'(bus.o_valid), 0);
      check("rst_down", int'(bus.o_key_down), 0);
    end
    rst = 1'b0;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("rst_pulses", pulses, 1);
    check_range("rst_pulse_at", first_pulse, 11, 15);
    check("rst_code", int'(bus.o_data), 3);
    check("rst_proto", bad, 0);
    bus.i_key = 10'h3FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("rst_rel_down", int'(bus.o_key_down), 0);

    // ---------------- Clean press of key 5 ----------------
    bus.i_key = 10'h3EF;
    run_cycles(40, pulses, first_pulse, first_low, bad);
    check("clean_pulses", pulses, 1);
    check_range("clean_pulse_at", first_pulse, 11, 15);
    check("clean_code", int'(bus.o_data), 5);
    check("clean_down", int'(bus.o_key_down), 1);
    check("clean_proto", bad, 0);
    bus.i_key = 10'h3FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check_range("clean_fall_at", first_low, 11, 15);
    check("clean_rel_pulses", pulses, 0);
    check("clean_rel_code", int'(bus.o_data), 5);

    // ---------------- Bounce on key 1, then hold ----------------
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      bus.i_key = 10'h3FE;
      run_cycles(5, pulses, first_pulse, first_low, bad);
      sum += pulses;
      bus.i_key = 10'h3FF;
      run_cycles(5, pulses, first_pulse, first_low, bad);
      sum += pulses;
    end
    check("bounce_no_pulse", sum, 0);
    check("bounce_down", int'(bus.o_key_down), 0);
    bus.i_key = 10'h3FE;
    run_cycles(30, pulses, first_pulse, first_low, bad);
    check("bounce_hold_pulses", pulses, 1);
    check("bounce_hold_code", int'(bus.o_data), 1);
    bus.i_key = 10'h3FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("bounce_rel_down", int'(bus.o_key_down), 0);

    // ---------------- Simultaneous keys 2 and 7, no rollover ----------------
    bus.i_key = 10'h3BD;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("simul_pulses", pulses, 1);
    check("simul_code", int'(bus.o_data), 2);
    bus.i_key = 10'h3BF;
    run_cycles(30, pulses, first_pulse, first_low, bad);
    check("ignore_pulses", pulses, 0);
    check("ignore_low_seen", first_low, -1);
    check("ignore_code", int'(bus.o_data), 2);
    bus.i_key = 10'h3FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("simul_rel_down", int'(bus.o_key_down), 0);
    bus.i_key = 10'h1FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("key10_pulses", pulses, 1);
    check("key10_code", int'(bus.o_data), 10);
    check("key10_proto", bad, 0);
    bus.i_key = 10'h3FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("key10_rel_down", int'(bus.o_key_down), 0);

    // ---------------- Reset mid-debounce with key 2 held ----------------
    bus.i_key = 10'h3FD;
    run_cycles(6, pulses, first_pulse, first_low, bad);
    check("midrst_pre_pulses", pulses, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_data", int'(bus.o_data), 0);
    check("midrst_valid", int'(bus.o_valid), 0);
    rst = 1'b0;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("midrst_pulses", pulses, 1);
    check_range("midrst_pulse_at", first_pulse, 11, 15);
    check("midrst_code", int'(bus.o_data), 2);
    bus.i_key = 10'h3FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check("midrst_rel_down", int'(bus.o_key_down), 0);

    // ---------------- Long hold of key 4 ----------------
    bus.i_key = 10'h3F7;
    run_cycles(200, pulses, first_pulse, first_low, bad);
    check("long_pulses", pulses, 1);
    check("long_code", int'(bus.o_data), 4);
    check("long_down", int'(bus.o_key_down), 1);
    check("long_proto", bad, 0);
    bus.i_key = 10'h3FF;
    run_cycles(20, pulses, first_pulse, first_low, bad);
    check_range("long_fall_at", first_low, 11, 15);
    check("long_rel_pulses", pulses, 0);
    check("long_rel_code", int'(bus.o_data), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
